uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter START_TIMEOUT, default 64: max clk cycles tx_send is held waiting for tx_tip to rise; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of sent_count.
REQ-003 clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 has a byte pending; held with data0 until ack0.
REQ-006 data0  input  8  requester 0 byte.
REQ-007 ack0  output  1  one-cycle pulse: data0 latched.
REQ-008 req1  input  1  requester 1 has a byte pending; held with data1 until ack1.
REQ-009 data1  input  8  requester 1 byte.
REQ-010 ack1  output  1  one-cycle pulse: data1 latched.
REQ-011 tx_data  output  8  byte to the UART transmitter data input; registered.
REQ-012 tx_send  output  1  send request to the UART transmitter; registered.
REQ-013 tx_tip  input  1  transmission-in-progress flag from the UART transmitter.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 grant_id  output  1  requester currently or last served.
REQ-016 err_timeout  output  1  one-cycle pulse: tx_tip did not rise within START_TIMEOUT.
REQ-017 sent_count  output  CNT_W  number of bytes completed; wraps modulo 2^CNT_W.

Function
REQ-018 FSM states SHALL be IDLE, SEND, WAIT_DONE.
REQ-019 IDLE: when tx_tip=0 and (req0|req1), the next edge SHALL latch the selected byte into tx_data, set grant_id, pulse the matching ack for exactly 1 cycle, clear the timeout counter, and enter SEND.
REQ-020 IDLE with tx_tip=1: no grant, no ack; requests wait.
REQ-021 Arbitration SHALL be round-robin: with both requests present, grant the requester not granted last; with one request, grant that one.
REQ-022 After reset, requester 0 SHALL have priority on the first simultaneous request.
REQ-023 The round-robin pointer SHALL update only on successful completion (WAIT_DONE -> IDLE), not on timeout.
REQ-024 SEND: tx_send=1; tx_data stable; timeout counter increments each cycle.
REQ-025 SEND with tx_tip=1: next edge SHALL enter WAIT_DONE and drop tx_send to 0.
REQ-026 SEND, counter reaching START_TIMEOUT with tx_tip still 0: next edge SHALL drop tx_send, pulse err_timeout 1 cycle, enter IDLE; byte discarded (already acked), sent_count unchanged.
REQ-027 tx_tip=1 takes precedence over timeout in the same cycle.
REQ-028 WAIT_DONE: tx_send=0; on tx_tip=0, next edge SHALL enter IDLE and increment sent_count by 1.
REQ-029 Minimum spacing between consecutive acks SHALL be 4 cycles (IDLE, SEND, WAIT_DONE, IDLE).
REQ-030 A requester keeping req high after its ack SHALL be treated as presenting a new byte.
REQ-031 tx_data SHALL change only on a grant edge.
REQ-032 ack0 and ack1 SHALL never be high in the same cycle.
REQ-033 sent_count SHALL wrap from 2^CNT_W-1 to 0 without a flag.

Reset
REQ-034 On rst=1: state IDLE, tx_send=0, tx_data=8'h00, ack0=ack1=0, busy=0, grant_id=0, err_timeout=0, sent_count=0, round-robin pointer favours requester 0.
REQ-035 Reset mid-transfer SHALL abandon the byte without a count; after reset the block SHALL wait in IDLE until tx_tip=0 before the next grant.
REQ-036 rst SHALL override all other inputs in the same cycle.

Verification
REQ-037 Single byte: req0=1, data0=8'hA5; UART model raises tx_tip 3 cycles after tx_send and holds it 20 cycles -> ack0 pulse, tx_data=8'hA5, tx_send high 3 cycles, sent_count 0->1, busy returns low.
REQ-038 Round-robin: req0 and req1 held high for 4 bytes each (8'h10.., 8'h20..) -> serialized order 10,20,11,21,12,22,13,23 and sent_count=8.
REQ-039 Timeout: START_TIMEOUT=8, tx_tip tied 0, req1=1 -> ack1 pulse, tx_send high 8 cycles, err_timeout pulse, sent_count stays 0, next grant goes to requester 1 again.
REQ-040 Blocked start: tx_tip=1 in IDLE while req0=1 -> no ack until tx_tip falls, then ack0 on the next edge.
REQ-041 Reset mid-transfer: rst asserted in WAIT_DONE -> all outputs at reset values the next cycle; with tx_tip still 1, no grant until it falls.
REQ-042 Wrap: CNT_W=4, 17 completed bytes -> sent_count=1.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter feeding bytes from two requesters into a UART transmitter,
// with a start timeout on the transmitter handshake and a completed-byte counter.
module uart_tx_scheduler #(
    parameter int START_TIMEOUT = 64,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [7:0]       data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [7:0]       data1,
    output logic             ack1,
    output logic [7:0]       tx_data,
    output logic             tx_send,
    input  logic             tx_tip,
    output logic             busy,
    output logic             grant_id,
    output logic             err_timeout,
    output logic [CNT_W-1:0] sent_count
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;
    state_t           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d, tmo_q, tmo_d;
    logic             tx_send_q, tx_send_d, ack0_q, ack0_d, ack1_q, ack1_d;
    logic             grant_q, grant_d, err_q, err_d, rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start, sel, timeout, done;
    // rr_q names the requester that wins a simultaneous request
    assign sel     = (req0 & req1) ? rr_q : req1;
    assign start   = (state_q == IDLE) & ~tx_tip & (req0 | req1);
    assign timeout = (state_q == SEND) & ~tx_tip & (tmo_q == 8'(START_TIMEOUT - 1));
    assign done    = (state_q == WAIT_DONE) & ~tx_tip;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
            tmo_q     <= 8'h00;
            tx_send_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            grant_q   <= 1'b0;
            err_q     <= 1'b0;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tmo_q     <= tmo_d;
            tx_send_q <= tx_send_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = start ? SEND : IDLE;
            SEND:      state_d = tx_tip ? WAIT_DONE : (timeout ? IDLE : SEND);
            WAIT_DONE: state_d = tx_tip ? WAIT_DONE : IDLE;
            default:   state_d = IDLE;
        endcase
    end
    always_comb begin
        tx_data_d = start ? (sel ? data1 : data0) : tx_data_q;
        grant_d   = start ? sel : grant_q;
        ack0_d    = start & ~sel;
        ack1_d    = start & sel;
        tx_send_d = state_d == SEND;
        err_d     = timeout;
        tmo_d     = start ? 8'h00 : (state_q == SEND ? tmo_q + 8'h01 : tmo_q);
        cnt_d     = cnt_q + CNT_W'(done);
        rr_d      = done ? ~grant_q : rr_q;
    end
    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign grant_id    = grant_q;
    assign err_timeout = err_q;
    assign sent_count  = cnt_q;
    assign busy        = state_q != IDLE;
endmodule
